// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (optional DIV_EARLY_OUT_EN)
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  // dvd starts as |dividend| and shifts quotient bits in from the bottom
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic              sign_q;
  logic              sign_r;

  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  // Operand magnitudes; only signed divides take absolute values
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    abs1    = op1_neg ? -opdata1_i : opdata1_i;
    abs2    = op2_neg ? -opdata2_i : opdata2_i;
  end

  // One restoring step. The shifted remainder can reach DATA_W+1 bits; when
  // its top bit is set it certainly exceeds the divisor, and the true
  // difference is below the divisor so the low DATA_W bits of diff are exact.
  always_comb begin
    shifted  = {rem, dvd[DATA_W-1]};
    diff     = shifted - {1'b0, dvs};
    ge       = rem[DATA_W-1] | ~diff[DATA_W];
    rem_next = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quot_fix = sign_q ? -dvd : dvd;
    rem_fix  = sign_r ? -rem : rem;
  end

  assign busy_o = (state == S_BYZERO) || (state == S_ON);

  // Sequencing FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs1 < abs2) begin
              state    <= S_END;
              result_o <= {opdata1_i, {DATA_W{1'b0}}};
              ready_o  <= 1'b1;
`endif
            end else begin
              dvd    <= abs1;
              dvs    <= abs2;
              rem    <= '0;
              sign_q <= op1_neg ^ op2_neg;
              sign_r <= op1_neg;
              cnt    <= '0;
              state  <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state <= S_FREE;
          end else begin
            state    <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state <= S_FREE;
          end else if (cnt == CNT_W'(DATA_W)) begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
            state    <= S_END;
          end else begin
            rem <= rem_next;
            dvd <= {dvd[DATA_W-2:0], ge};
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            state   <= S_FREE;
            ready_o <= 1'b0;
          end
        end
        default: state <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized self-checking bench for div_seq against an arithmetic model
module tb_div_seq;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic           start;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] last_res = '0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {remainder, quotient} from ordinary integer arithmetic (truncating division)
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  function automatic bit early(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    return (b != 0) && (ma < mb);
`else
    return (ma < mb) && 1'b0;
`endif
  endfunction

  // Latency counted in rising edges, the start-sampling edge being the first
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int exp_lat;
    int exp_busy;
    int n;
    int busy_n;
    bit got;
    exp = model(sgn, a, b);
    if (b == 0) begin
      exp_lat = 2; exp_busy = 1;
    end else if (early(sgn, a, b)) begin
      exp_lat = 1; exp_busy = 0;
    end else begin
      exp_lat = W + 2; exp_busy = W + 1;
    end
    signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
    n = 0; busy_n = 0; got = 0;
    while (n < 80 && !got) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
      if (ready) got = 1;
      opdata1 = $urandom; opdata2 = $urandom; signed_div = ~signed_div;
    end
    check($sformatf("%s ready", tag), 64'(got), 64'd1);
    check($sformatf("%s latency", tag), 64'(n), 64'(exp_lat));
    check($sformatf("%s busy cycles", tag), 64'(busy_n), 64'(exp_busy));
    check($sformatf("%s result", tag), result, exp);
    @(posedge clk); #1;
    check($sformatf("%s hold ready", tag), 64'(ready), 64'd1);
    check($sformatf("%s hold result", tag), result, exp);
    start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s drop ready", tag), 64'(ready), 64'd0);
    check($sformatf("%s drop busy", tag), 64'(busy), 64'd0);
    check($sformatf("%s drop result", tag), result, exp);
    last_res = exp;
  endtask

  initial begin
    int hits;
    bit sgn;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;

    run_div("u100/7", 1'b0, 32'd100, 32'd7);
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("uFFFFFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_div("u/0", 1'b0, 32'd1234, 32'd0);
    run_div("s/0", 1'b1, 32'hFFFF_0000, 32'd0);
    run_div("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("u3/10", 1'b0, 32'd3, 32'd10);
    run_div("s-3/10", 1'b1, 32'hFFFF_FFFD, 32'd10);

    // Flush during iteration 10: nothing completes, old result stays
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul busy", 64'(busy), 64'd0);
    check("annul ready", 64'(ready), 64'd0);
    check("annul result", result, last_res);
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready || busy) hits++;
    end
    check("annul stays idle", 64'(hits), 64'd0);

    // Reset in the middle of a division
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst result", result, 64'd0);
    check("midrst ready", 64'(ready), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    run_div("u100/7 again", 1'b0, 32'd100, 32'd7);

    // Start together with annul from FREE is ignored
    start = 1'b1; annul = 1'b1; opdata2 = 32'd3;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready || busy) hits++;
    end
    check("start+annul idle", 64'(hits), 64'd0);
    start = 1'b0; annul = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        3: b = -32'($urandom_range(1, 15));
        default: begin
          a = $urandom_range(0, 20);
          b = $urandom_range(1, 40);
        end
      endcase
      run_div($sformatf("rnd%0d", i), sgn, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
